// File: rtl/ppreg_pkg.sv
// Shared types for the elastic pipeline register: D->E payload layout, skid FSM states, counter helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ppreg_pkg;

    // Packed decode->execute bundle carried as the default opaque payload.
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] operand1;
        logic [31:0] operand2;
        logic [3:0]  mem_op;
        logic [4:0]  alu_op;
        logic [1:0]  wb_src;
        logic [3:0]  data_dependency_check;
        logic [14:0] csr_op;
    } de_payload_t;

    localparam int DE_PAYLOAD_W = $bits(de_payload_t);

    // Occupancy of the two-entry skid variant: main register, then main+skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Saturating increment for a counter of width w (w <= 32); never wraps.
    function automatic logic [31:0] bp_sat_inc(input logic [31:0] cnt, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (cnt >= max_v) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/ppreg_skid.sv
// Two-entry skid buffer (main + skid register) with a registered in_ready; output always from main.
// Latency: 1 cycle from accept to out_valid when empty; strict FIFO order.
// Backpressure: in_ready is a flop (low only while skid is full), no combinational path from out_ready.
module ppreg_skid
    import ppreg_pkg::*;
#(
    parameter int WIDTH = DE_PAYLOAD_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             skid_valid_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // State register; skid_valid_q mirrors "next state is TWO" so in_ready comes straight off a flop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= EMPTY;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            skid_valid_q <= (state_d == TWO);
        end
    end

    // Next-state: flush returns to EMPTY from anywhere, otherwise track occupancy.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_d = TWO;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                TWO:     if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Load decode: which register captures what this cycle (nothing while flushing).
    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: ld_main_in = in_fire;
                ONE: begin
                    ld_main_in = in_fire & out_fire;
                    ld_skid    = in_fire & ~out_fire;
                end
                TWO:   ld_main_skid = out_fire;
                default: ;
            endcase
        end
    end

    // Payload registers: optional clear on flush, otherwise load only on an accepted write or skid drain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (clr) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)        main_q <= in_data;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= in_data;
        end
    end

endmodule

// File: rtl/elastic_ppreg.sv
// Flow-controlled pipeline stage register with flush and a saturating backpressure counter (PPREG_SKID_EN selects 2-entry skid).
// Latency: 1 cycle from accept to out_valid.
// Backpressure: default in_ready = ~out_valid | out_ready (combinational); with PPREG_SKID_EN in_ready is registered.
module elastic_ppreg
    import ppreg_pkg::*;
#(
    parameter int WIDTH          = DE_PAYLOAD_W,
    parameter int CNT_W          = 16,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] bp_cnt
);

    // Payload clear is only ever requested alongside a flush.
    logic clr;
    assign clr = flush & CLEAR_ON_FLUSH;

`ifdef PPREG_SKID_EN
    ppreg_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (flush),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );
`else
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             in_fire;

    assign in_ready  = ~valid_q | out_ready;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Valid: flush kills the entry; otherwise refresh whenever the stage can accept.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)         valid_q <= 1'b0;
        else if (flush)    valid_q <= 1'b0;
        else if (in_ready) valid_q <= in_valid;
    end

    // Payload: optional clear on flush, load only on an accepted write that is not being flushed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                 data_q <= '0;
        else if (clr)              data_q <= '0;
        else if (in_fire && !flush) data_q <= in_data;
    end
`endif

    // Backpressure counter: cycles with a held entry the consumer refuses, excluding flush cycles.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            bp_cnt <= '0;
        else if (out_valid && !out_ready && !flush)
            bp_cnt <= CNT_W'(bp_sat_inc(32'(bp_cnt), CNT_W));
    end

endmodule

// File: tb/tb_elastic_ppreg.sv
module tb_elastic_ppreg;

    localparam int W      = 16;
    localparam int CW     = 3;
    localparam int BP_MAX = (1 << CW) - 1;
`ifdef PPREG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] bp_cnt;

    always #5 clk = ~clk;

    elastic_ppreg #(
        .WIDTH          (W),
        .CNT_W          (CW),
        .CLEAR_ON_FLUSH (1'b1)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .bp_cnt    (bp_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: a FIFO of capacity CAP ----------------
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last = '0;
    int           m_bp = 0;
    bit           m_in_fire = 1'b0;
    bit           m_rdy_v;
    bit           m_vld_v;

    function automatic bit m_rdy();
        if (CAP == 1) return (mq.size() == 0) || out_ready;
        else          return mq.size() < CAP;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            m_last    = '0;
            m_bp      = 0;
            m_in_fire = 1'b0;
        end else begin
            m_rdy_v   = m_rdy();
            m_vld_v   = mq.size() > 0;
            m_in_fire = 1'b0;
            if (flush) begin
                mq.delete();
                m_last = '0;
            end else begin
                if (m_vld_v && !out_ready && m_bp < BP_MAX) m_bp++;
                if (m_vld_v && out_ready) m_last = mq.pop_front();
                if (in_valid && m_rdy_v) begin
                    mq.push_back(in_data);
                    m_in_fire = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare + ordering scoreboard ----------------
    bit           rx_on = 1'b0;
    logic [W-1:0] rx_exp = '0;
    int           rx_cnt = 0;

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_rdy()));
        if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        else               chk("out_data_idle", 32'(out_data), 32'(m_last));
        chk("bp_cnt", 32'(bp_cnt), 32'(m_bp));
        if (rx_on && nrst && out_valid && out_ready && !flush) begin
            chk("rx_order", 32'(out_data), 32'(rx_exp));
            rx_exp = rx_exp + 1'b1;
            rx_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) step();
        nrst = 1'b1;
        step();
    endtask

    logic [W-1:0] cur;
    int           tx;

    initial begin
        #1 nrst = 1'b0;
        do_reset();

        // 1. asynchronous reset mid-cycle with an entry held and in_valid high
        in_valid = 1'b1; in_data = 16'h12; out_ready = 1'b0;
        step(); step();
        chk("t1_pre_bp", 32'(bp_cnt), 32'd1);
        chk("t1_pre_data", 32'(out_data), 32'h12);
        #2 nrst = 1'b0;
        #1;
        chk("t1_rst_valid", 32'(out_valid), 32'd0);
        chk("t1_rst_data", 32'(out_data), 32'd0);
        chk("t1_rst_bp", 32'(bp_cnt), 32'd0);
        step(); step();
        in_valid = 1'b0;
        nrst = 1'b1;
        step();
        chk("t1_post_rdy", 32'(in_ready), 32'd1);
        chk("t1_post_valid", 32'(out_valid), 32'd0);

        // 2. streaming 1..8 with out_ready held high
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = W'(k);
            step();
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_data", 32'(out_data), 32'(k));
            chk("t2_rdy", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // 3. backpressure for 5 cycles with 0xA held and 0xB offered
        do_reset();
        in_valid = 1'b1; in_data = 16'hA; out_ready = 1'b0;
        step();
        chk("t3_first", 32'(out_data), 32'hA);
        in_data = 16'hB;
        repeat (5) step();
        chk("t3_bp", 32'(bp_cnt), 32'd5);
        chk("t3_hold", 32'(out_data), 32'hA);
        chk("t3_rdy_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
`ifdef PPREG_SKID_EN
        chk("t3_second_valid", 32'(out_valid), 32'd1);
        chk("t3_second_data", 32'(out_data), 32'hB);
        step();
`endif
        chk("t3_empty", 32'(out_valid), 32'd0);
        chk("t3_bp_kept", 32'(bp_cnt), 32'd5);

        // 4. flush with simultaneous in_fire, then flush does not touch bp_cnt
        do_reset();
        in_valid = 1'b1; in_data = 16'h33; out_ready = 1'b0;
        step();
        chk("t4_held", 32'(out_data), 32'h33);
        flush = 1'b1; in_data = 16'h55; out_ready = 1'b1;
        step();
        chk("t4_fl_valid", 32'(out_valid), 32'd0);
        chk("t4_fl_data", 32'(out_data), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("t4_no55_valid", 32'(out_valid), 32'd0);
        chk("t4_no55_data", 32'(out_data), 32'd0);
        in_valid = 1'b1; in_data = 16'h44; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        chk("t4_bp_before", 32'(bp_cnt), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_bp_after", 32'(bp_cnt), 32'd1);
        chk("t4_fl2_valid", 32'(out_valid), 32'd0);
        chk("t4_fl2_data", 32'(out_data), 32'd0);

        // 5. saturation of a 3-bit counter
        do_reset();
        in_valid = 1'b1; in_data = 16'h77; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("t5_bp7", 32'(bp_cnt), 32'd7);
        repeat (3) step();
        chk("t5_bp_sat", 32'(bp_cnt), 32'd7);
        chk("t5_hold", 32'(out_data), 32'h77);

        // 6. random valid/ready traffic: order, no loss, no duplication
        do_reset();
        cur = 16'h100; rx_exp = 16'h100; rx_cnt = 0; tx = 0;
        in_data = cur;
        rx_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            if (m_in_fire) begin
                tx++;
                cur = cur + 1'b1;
                in_data = cur;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        rx_on = 1'b0;
        chk("t6_count", 32'(rx_cnt), 32'(tx));
        chk("t6_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
